store_write_buffer: RTL
=======================

Name: store_write_buffer

Overview:
- Posted-store buffer between the single-cycle MIPS core's data-memory port and dmem.
- Stores are queued in a small FIFO and retired to dmem on cycles when the core is not loading. This removes store-to-memory coupling from the core's critical path.
- Loads take the dmem port directly. A load whose word address matches a pending store stalls the core until that store has drained.

Parameters:
- DEPTH, 4, number of store entries; power of two, 2..16.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cpu_we  input  1  store request (core memwrite)
- cpu_re  input  1  load request (core memtoreg)
- cpu_addr  input  32  byte address (core aluout)
- cpu_wdata  input  32  store data (core writedata)
- cpu_bytes  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
- cpu_stall  output  1  core must hold its PC and request this cycle
- mem_we  output  1  dmem write strobe
- mem_addr  output  32  dmem address
- mem_wdata  output  32  dmem write data
- mem_bytes  output  2  dmem access size
- wb_count  output  AW+1  occupied entries
- wb_empty  output  1  wb_count == 0

Behaviour:
- State: DEPTH entries of {addr[31:0], wdata[31:0], bytes[1:0]}, head ptr, tail ptr, count. All are registered. mem_* and cpu_stall are combinational from state and inputs.
- Reset (sync):
  - head = tail = count = 0.
  - Next cycle mem_we = 0 and cpu_stall = 0 unless a request is present.
  - A reset mid-drain discards every pending entry; no further mem_we is issued for them.
- full = (count == DEPTH); evaluated on the registered count only. A drain in the same cycle does not clear full.
- Hazard:
  - hit = cpu_re && some valid entry has entry.addr[31:2] == cpu_addr[31:2].
  - Comparison is at word granularity regardless of size.
- cpu_stall = (cpu_we && full) || hit.
- Port arbitration, priority top-down:
  1. cpu_re && !hit: read cycle. mem_addr = cpu_addr, mem_bytes = cpu_bytes, mem_we = 0. No drain this cycle.
  2. count > 0: drain cycle. mem_we = 1 and mem_addr/wdata/bytes = head entry. head increments and wraps modulo DEPTH.
  3. Otherwise idle: mem_we = 0, mem_addr = cpu_addr.
- Enqueue:
  - cpu_we && !full writes the entry at tail; tail increments and wraps.
  - Enqueue latency is 1 cycle: an entry written at edge N is drainable in cycle N+1 at the earliest.
- count update: +1 on enqueue only, -1 on drain only, unchanged when both or neither occur in a cycle.
- cpu_we && cpu_re together: treated as a store only; cpu_re is ignored.
- A stalled store is not enqueued; the core re-presents it.
- Stalled loads: during a hit stall the port is free, so the drain proceeds. The stall releases in the cycle after the last matching entry leaves.
- Ordering: stores retire strictly FIFO. No merging or coalescing.

Optional Feature:
- Macro: WBUF_BYPASS_EN.
- Defined: when count == 0 and cpu_we && !cpu_re, the store is written straight through the same cycle.
  - mem_we = 1 and mem_addr/wdata/bytes = cpu inputs.
  - Nothing is enqueued; count stays 0.
- Undefined: every store is enqueued; a store to an empty buffer reaches dmem no earlier than the next cycle.

Test Plan:
- Single store, default build: reset, then cpu_we addr 0x40 data 0xDEADBEEF bytes 00 for one cycle. Required: wb_count goes 0→1→0. mem_we = 1 in the cycle after the store with mem_addr 0x40 and mem_wdata 0xDEADBEEF. cpu_stall stays 0.
- Fill and full stall: 5 back-to-back stores to 0x00, 0x04, 0x08, 0x0C, 0x10 with cpu_re held 1 on an unrelated address 0x80 so nothing drains. Required: 5th store sees cpu_stall = 1 while count = 4. Once cpu_re drops, drains to dmem occur in order 0x00..0x0C, then 0x10 is accepted.
- RAW hazard: store 0x1234 to 0x20, then next cycle a load from 0x22 bytes 01. Required: cpu_stall = 1 for exactly 1 cycle while mem_we = 1 to 0x20. Next cycle the load reads 0x22 with mem_we = 0; the core sees 0x1234's upper half from dmem.
- Non-matching load: one pending store to 0x30, load from 0x34. Required: no stall. Load uses the port; drain of 0x30 is deferred one cycle.
- Wrap-around: 10 stores, one every other cycle, with no loads. Required: each drains, pointers wrap past 3→0, and all 10 addresses appear on mem_addr in order.
- Reset mid-drain: 3 queued stores, assert reset for 1 cycle. Required: wb_count = 0 and wb_empty = 1 afterwards, with no further mem_we. With WBUF_BYPASS_EN, a store to an empty buffer shows mem_we = 1 the same cycle and count stays 0.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// ---------------------------------------------------------------------------
// store_write_buffer_if
//   Bundles the core-side request/stall signals, the dmem-side port and the
//   occupancy status of the posted-store buffer.
//
//   Handshake: a core request (cpu_we or cpu_re, with cpu_addr/cpu_wdata/
//   cpu_bytes) is accepted in any cycle where cpu_stall is low.  While
//   cpu_stall is high the core holds its request unchanged and re-presents
//   it.  The dmem side has no back-pressure: mem_we = 1 is a completed write
//   in that cycle, and mem_we = 0 with a load present is a read of mem_addr.
//
//   Parameter AW : pointer width, log2 of the buffer depth (wb_count is AW+1).
//
//   Modports:
//     slave  - the buffer: takes cpu_* requests, drives stall, mem_* and status
//     master - the core / bench side
// ---------------------------------------------------------------------------
interface store_write_buffer_if #(
    parameter int AW = 2
);
    logic          cpu_we;
    logic          cpu_re;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [1:0]    cpu_bytes;
    logic          cpu_stall;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [1:0]    mem_bytes;
    logic [AW:0]   wb_count;
    logic          wb_empty;

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata, cpu_bytes,
        output cpu_stall, mem_we, mem_addr, mem_wdata, mem_bytes,
        output wb_count, wb_empty
    );

    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata, cpu_bytes,
        input  cpu_stall, mem_we, mem_addr, mem_wdata, mem_bytes,
        input  wb_count, wb_empty
    );
endinterface

// File: rtl/store_write_buffer.sv
// ---------------------------------------------------------------------------
// store_write_buffer
//   Posted-store FIFO between a single-cycle core's data port and dmem.
//   Stores are queued and retired to dmem in FIFO order on cycles where the
//   core is not loading.  Loads use the dmem port directly; a load whose word
//   address matches a pending store stalls until that store has drained.
//
//   Parameters:
//     DEPTH - number of store entries (power of two, 2..16)
//     AW    - pointer width, log2(DEPTH)
//
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous, active-high reset (discards all pending stores)
//     bus   - store_write_buffer_if.slave: cpu_* request in, cpu_stall,
//             mem_* dmem port, wb_count / wb_empty status out
//
//   Build option:
//     WBUF_BYPASS_EN - when defined, a store (without load) arriving at an
//                      empty buffer is written straight to dmem in the same
//                      cycle instead of being queued.
// ---------------------------------------------------------------------------
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    store_write_buffer_if.slave  bus
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Entry storage (datapath only, no reset needed: validity comes from
    // head/count).
    logic [31:0]   ent_addr_q  [DEPTH];
    logic [31:0]   ent_wdata_q [DEPTH];
    logic [1:0]    ent_bytes_q [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic          full;
    logic          hit;
    logic          rd_cycle;
    logic          drain;
    logic          bypass;
    logic          enq;
    logic [AW-1:0] offs;

    // full looks only at the registered count, so a drain in the same cycle
    // does not let a store in.
    assign full = (count_q == DEPTH_C);

    // Word-granular hazard check against every occupied entry.  An entry i is
    // occupied when its distance from head is below count.  A store with a
    // simultaneous load flag is a store only, so it never raises a hazard.
    always_comb begin
        hit  = 1'b0;
        offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = AW'(i) - head_q;
            if (({1'b0, offs} < count_q) &&
                (ent_addr_q[i][31:2] == bus.cpu_addr[31:2])) begin
                hit = 1'b1;
            end
        end
        hit = hit && bus.cpu_re && !bus.cpu_we;
    end

`ifdef WBUF_BYPASS_EN
    assign bypass = (count_q == '0) && bus.cpu_we && !bus.cpu_re && !reset;
`else
    assign bypass = 1'b0;
`endif

    // Port arbitration: an asserted load flag claims the port whenever it is
    // not hazard-stalled (this also holds the port when it comes with a
    // store, so no drain happens that cycle).  Otherwise the head entry
    // drains.  Drains are suppressed while reset is high so that a reset
    // mid-drain issues no further writes.
    always_comb begin
        rd_cycle      = bus.cpu_re && !hit;
        drain         = !rd_cycle && (count_q != '0) && !reset;
        enq           = bus.cpu_we && !full && !bypass;

        bus.mem_we    = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_bytes = bus.cpu_bytes;
        if (drain) begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = ent_addr_q[head_q];
            bus.mem_wdata = ent_wdata_q[head_q];
            bus.mem_bytes = ent_bytes_q[head_q];
        end else if (bypass) begin
            bus.mem_we    = 1'b1;
        end

        head_d  = drain ? head_q + 1'b1 : head_q;
        tail_d  = enq   ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        case ({enq, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign bus.cpu_stall = (bus.cpu_we && full) || hit;
    assign bus.wb_count  = count_q;
    assign bus.wb_empty  = (count_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq) begin
                ent_addr_q[tail_q]  <= bus.cpu_addr;
                ent_wdata_q[tail_q] <= bus.cpu_wdata;
                ent_bytes_q[tail_q] <= bus.cpu_bytes;
            end
        end
    end

endmodule
